// File: rtl/branch_pc_control_pkg.sv
// rtl/branch_pc_control_pkg.sv - branch flag, ID-state and PC increment constants
package branch_pc_control_pkg;

    // Branch flag encodings driven by the decoder
    localparam logic [2:0] FLAG_NONE = 3'b000;
    localparam logic [2:0] FLAG_JR   = 3'b001;
    localparam logic [2:0] FLAG_JALR = 3'b010;
    localparam logic [2:0] FLAG_BEQ  = 3'b011;
    localparam logic [2:0] FLAG_BNE  = 3'b100;
    localparam logic [2:0] FLAG_J    = 3'b101;

    // ID-stage state encodings
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_BUBBLE = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;

    localparam int PC_INCREMENT = 4;

endpackage

// File: rtl/branch_pc_control_target.sv
// rtl/branch_pc_control_target.sv - combinational branch/jump resolution in ID
module branch_target_calc
    import branch_pc_control_pkg::*;
#(
    parameter int CANT_BITS_PC                       = 32,
    parameter int CANT_BITS_REGISTROS                = 32,
    parameter int CANT_BITS_IMMEDIATE                = 16,
    parameter int CANT_BITS_INSTRUCTION_INDEX_BRANCH = 26,
    parameter int CANT_BITS_FLAG_BRANCH              = 3
) (
    input  logic [CANT_BITS_FLAG_BRANCH-1:0]              i_flag_branch,
    input  logic [CANT_BITS_REGISTROS-1:0]                i_dato_reg_A,
    input  logic [CANT_BITS_REGISTROS-1:0]                i_dato_reg_B,
    input  logic [CANT_BITS_IMMEDIATE-1:0]                i_immediate,
    input  logic [CANT_BITS_INSTRUCTION_INDEX_BRANCH-1:0] i_instruction_index_branch,
    input  logic [CANT_BITS_PC-1:0]                       i_pc4,
    output logic                                          o_taken,
    output logic [CANT_BITS_PC-1:0]                       o_target
);

    localparam int UPPER_BITS = CANT_BITS_PC - CANT_BITS_INSTRUCTION_INDEX_BRANCH - 2;

    logic [CANT_BITS_PC-1:0] imm_ext;
    logic [CANT_BITS_PC-1:0] rel_target;
    logic [CANT_BITS_PC-1:0] abs_target;

    assign imm_ext    = {{(CANT_BITS_PC-CANT_BITS_IMMEDIATE){i_immediate[CANT_BITS_IMMEDIATE-1]}},
                         i_immediate};
    // Offsets are in words; the add wraps modulo 2^PC width
    assign rel_target = i_pc4 + (imm_ext << 2);
    assign abs_target = {i_pc4[CANT_BITS_PC-1 -: UPPER_BITS], i_instruction_index_branch, 2'b00};

    always_comb begin
        o_taken  = 1'b0;
        o_target = i_pc4;
        case (i_flag_branch)
            FLAG_JR, FLAG_JALR: begin
                o_taken  = 1'b1;
                o_target = i_dato_reg_A[CANT_BITS_PC-1:0];
            end
            FLAG_BEQ: begin
                o_taken  = (i_dato_reg_A == i_dato_reg_B);
                o_target = rel_target;
            end
            FLAG_BNE: begin
                o_taken  = (i_dato_reg_A != i_dato_reg_B);
                o_target = rel_target;
            end
            FLAG_J: begin
                o_taken  = 1'b1;
                o_target = abs_target;
            end
            default: begin
                o_taken  = 1'b0;
                o_target = i_pc4;
            end
        endcase
    end

endmodule

// File: rtl/branch_pc_control.sv
// rtl/branch_pc_control.sv - ID-stage branch resolution, PC ownership and ID validity
module branch_pc_control
    import branch_pc_control_pkg::*;
#(
    parameter int CANT_BITS_PC                       = 32,
    parameter int CANT_BITS_REGISTROS                = 32,
    parameter int CANT_BITS_IMMEDIATE                = 16,
    parameter int CANT_BITS_INSTRUCTION_INDEX_BRANCH = 26,
    parameter int CANT_BITS_FLAG_BRANCH              = 3,
    parameter logic [CANT_BITS_PC-1:0] PC_INICIAL    = '0
) (
    input  logic                                          i_clock,
    input  logic                                          i_reset,
    input  logic                                          i_enable,
    input  logic                                          i_stall,
    input  logic                                          i_halt,
    input  logic [CANT_BITS_FLAG_BRANCH-1:0]              i_flag_branch,
    input  logic [CANT_BITS_IMMEDIATE-1:0]                i_immediate,
    input  logic [CANT_BITS_INSTRUCTION_INDEX_BRANCH-1:0] i_instruction_index_branch,
    input  logic [CANT_BITS_REGISTROS-1:0]                i_dato_reg_A,
    input  logic [CANT_BITS_REGISTROS-1:0]                i_dato_reg_B,
    output logic [CANT_BITS_PC-1:0]                       o_pc,
    output logic [CANT_BITS_PC-1:0]                       o_pc_id_plus4,
    output logic                                          o_valid_id,
    output logic                                          o_branch_taken,
    output logic                                          o_halted
);

    logic [CANT_BITS_PC-1:0] pc_q, pc_d;
    logic [CANT_BITS_PC-1:0] pc4_q, pc4_d;
    logic [1:0]              state_q, state_d;
    logic [CANT_BITS_PC-1:0] pc_plus4;
    logic [CANT_BITS_PC-1:0] target;
    logic                    taken;
    logic                    advance;

    branch_target_calc #(
        .CANT_BITS_PC                       (CANT_BITS_PC),
        .CANT_BITS_REGISTROS                (CANT_BITS_REGISTROS),
        .CANT_BITS_IMMEDIATE                (CANT_BITS_IMMEDIATE),
        .CANT_BITS_INSTRUCTION_INDEX_BRANCH (CANT_BITS_INSTRUCTION_INDEX_BRANCH),
        .CANT_BITS_FLAG_BRANCH              (CANT_BITS_FLAG_BRANCH)
    ) u_target (
        .i_flag_branch              (i_flag_branch),
        .i_dato_reg_A               (i_dato_reg_A),
        .i_dato_reg_B               (i_dato_reg_B),
        .i_immediate                (i_immediate),
        .i_instruction_index_branch (i_instruction_index_branch),
        .i_pc4                      (pc4_q),
        .o_taken                    (taken),
        .o_target                   (target)
    );

    assign pc_plus4       = pc_q + CANT_BITS_PC'(PC_INCREMENT);
    assign advance        = i_enable & ~i_stall;
    assign o_branch_taken = taken & (state_q == ST_RUN) & advance & ~i_halt;

    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        state_d = state_q;
        if (advance) begin
            case (state_q)
                ST_RUN: begin
                    // Halt wins over any branch decoded alongside it
                    if (i_halt) begin
                        state_d = ST_HALT;
                    end else if (taken) begin
                        pc_d    = target;
                        pc4_d   = pc_plus4;
                        state_d = ST_BUBBLE;
                    end else begin
                        pc_d  = pc_plus4;
                        pc4_d = pc_plus4;
                    end
                end
                ST_BUBBLE: begin
                    pc_d    = pc_plus4;
                    pc4_d   = pc_plus4;
                    state_d = ST_RUN;
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_BUBBLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            pc_q    <= PC_INICIAL;
            pc4_q   <= PC_INICIAL;
            state_q <= ST_BUBBLE;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            state_q <= state_d;
        end
    end

    assign o_pc          = pc_q;
    assign o_pc_id_plus4 = pc4_q;
    assign o_valid_id    = (state_q == ST_RUN);
    assign o_halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_branch_pc_control.sv
// tb/tb_branch_pc_control.sv - directed and randomized checks of branch_pc_control
module tb_branch_pc_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en, stall, halt;
    logic [2:0]  flag;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] reg_a, reg_b;
    logic [31:0] o_pc, o_pc_id_plus4;
    logic        o_valid_id, o_branch_taken, o_halted;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] m_pc, m_pc4;
    bit          m_valid, m_halted;

    always #5 clk = ~clk;

    branch_pc_control dut (
        .i_clock                    (clk),
        .i_reset                    (rst_n),
        .i_enable                   (en),
        .i_stall                    (stall),
        .i_halt                     (halt),
        .i_flag_branch              (flag),
        .i_immediate                (imm),
        .i_instruction_index_branch (idx),
        .i_dato_reg_A               (reg_a),
        .i_dato_reg_B               (reg_b),
        .o_pc                       (o_pc),
        .o_pc_id_plus4              (o_pc_id_plus4),
        .o_valid_id                 (o_valid_id),
        .o_branch_taken             (o_branch_taken),
        .o_halted                   (o_halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f == 3'd1 || f == 3'd2 || f == 3'd5) return 1'b1;
        if (f == 3'd3) return a == b;
        if (f == 3'd4) return a != b;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_target(input logic [2:0] f, input logic [15:0] im,
                                               input logic [25:0] ix, input logic [31:0] a,
                                               input logic [31:0] pc4);
        logic signed [15:0] simm;
        int                 off;
        simm = im;
        off  = simm;
        off  = off * 4;
        if (f == 3'd3 || f == 3'd4) return pc4 + 32'(off);
        if (f == 3'd5) return (pc4 & 32'hF000_0000) | (32'(ix) * 4);
        return a;
    endfunction

    task automatic check_state();
        chk("pc", o_pc, m_pc);
        chk("pc_id_plus4", o_pc_id_plus4, m_pc4);
        chk("valid_id", {31'b0, o_valid_id}, {31'b0, m_valid});
        chk("halted", {31'b0, o_halted}, {31'b0, m_halted});
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // Called at posedge+1; drives, checks the combinational flag, then clocks the model
    task automatic step(input bit e, input bit s, input bit h, input logic [2:0] f,
                        input logic [15:0] im, input logic [25:0] ix,
                        input logic [31:0] a, input logic [31:0] b);
        bit          exp_t;
        logic [31:0] tgt;
        en = e; stall = s; halt = h; flag = f; imm = im; idx = ix; reg_a = a; reg_b = b;
        #1;
        exp_t = m_valid && e && !s && !h && ref_taken(f, a, b);
        tgt   = ref_target(f, im, ix, a, m_pc4);
        chk("branch_taken", {31'b0, o_branch_taken}, {31'b0, exp_t});
        @(posedge clk);
        #1;
        if (e && !s && !m_halted) begin
            if (!m_valid) begin
                m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
            end else if (h) begin
                m_halted = 1'b1; m_valid = 1'b0;
            end else if (exp_t) begin
                m_pc4 = m_pc + 32'd4; m_pc = tgt; m_valid = 1'b0;
            end else begin
                m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            end
        end
        check_state();
    endtask

    task automatic nop();
        step(1, 0, 0, 3'd0, 16'h0, 26'h0, 32'h0, 32'h0);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        en = 0; stall = 0; halt = 0; flag = 0; imm = 0; idx = 0; reg_a = 0; reg_b = 0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // J while in BUBBLE is ignored, then straight-line fetch
        step(1, 0, 0, 3'd5, 16'h0, 26'h3FF, 32'h0, 32'h0);
        chk("bubble_j_ignored", o_pc, 32'h4);
        nop();
        chk("seq_pc8", o_pc, 32'h8);
        chk("seq_pc4_8", o_pc_id_plus4, 32'h8);
        nop();
        chk("seq_pc12", o_pc, 32'hC);
        nop();

        // BEQ backwards, taken then not taken
        step(1, 0, 0, 3'd3, 16'hFFFE, 26'h0, 32'd5, 32'd5);
        chk("beq_taken_pc", o_pc, 32'h8);
        chk("beq_bubble", {31'b0, o_valid_id}, 32'h0);
        nop();
        step(1, 0, 0, 3'd3, 16'hFFFE, 26'h0, 32'd5, 32'd6);
        chk("beq_not_taken_pc", o_pc, 32'h10);

        // JR into the upper region, then J keeps pc4[31:28]
        step(1, 0, 0, 3'd1, 16'h0, 26'h0, 32'h4000_000C, 32'h0);
        nop();
        chk("pc4_before_j", o_pc_id_plus4, 32'h4000_0010);
        step(1, 0, 0, 3'd5, 16'h0, 26'h100, 32'h0, 32'h0);
        chk("j_target", o_pc, 32'h4000_0400);
        nop();
        step(1, 0, 0, 3'd2, 16'h0, 26'h0, 32'h0000_ABC0, 32'h0);
        chk("jalr_target", o_pc, 32'h0000_ABC0);
        nop();

        // Taken BNE held by stall, then by enable low
        step(1, 1, 0, 3'd4, 16'h4, 26'h0, 32'd1, 32'd2);
        step(1, 1, 0, 3'd4, 16'h4, 26'h0, 32'd1, 32'd2);
        chk("stall_hold_pc", o_pc, 32'h0000_ABC4);
        step(1, 0, 0, 3'd4, 16'h4, 26'h0, 32'd1, 32'd2);
        chk("bne_after_stall", o_pc, 32'h0000_ABD4);
        nop();
        step(0, 0, 0, 3'd4, 16'h4, 26'h0, 32'd7, 32'd8);
        step(0, 0, 0, 3'd4, 16'h4, 26'h0, 32'd7, 32'd8);
        chk("enable_hold_pc", o_pc, 32'h0000_ABD8);
        step(1, 0, 0, 3'd4, 16'h4, 26'h0, 32'd7, 32'd8);
        chk("bne_after_enable", o_pc, 32'h0000_ABE8);
        nop();

        // Relative target and link value wrap at the top of the address space
        step(1, 0, 0, 3'd1, 16'h0, 26'h0, 32'hFFFF_FFF8, 32'h0);
        nop();
        step(1, 0, 0, 3'd3, 16'h0001, 26'h0, 32'd9, 32'd9);
        chk("beq_wrap_pc", o_pc, 32'h0);
        chk("pc4_wrap", o_pc_id_plus4, 32'h0);
        nop();

        // Halt beats J, stays frozen, async reset recovers
        step(1, 0, 1, 3'd5, 16'h0, 26'h100, 32'h0, 32'h0);
        chk("halt_pc", o_pc, 32'h4);
        chk("halted", {31'b0, o_halted}, 32'h1);
        nop();
        nop();
        chk("halt_frozen_pc", o_pc, 32'h4);
        async_reset();
        chk("reset_from_halt", {31'b0, o_halted}, 32'h0);

        for (int i = 0; i < 500; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ((m_halted && ($urandom % 4 == 0)) || ($urandom % 60 == 0)) begin
                async_reset();
            end else begin
                step(($urandom % 8) != 0, ($urandom % 6) == 0, ($urandom % 30) == 0,
                     3'($urandom % 8), 16'($urandom), 26'($urandom), a,
                     (($urandom % 2) == 0) ? a : 32'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
